// File: rtl/display_scan_mux.sv
// display_scan_mux: time-multiplexed scanner for common-anode 7-segment displays.
// It steps through the digits one slot at a time. Each slot opens with a dead time
// in which every anode is off, to avoid ghosting. Digit values and decimal points
// are latched once per frame, so a frame is never drawn from two different values.
module display_scan_mux #(
   parameter int NUM_DIGITS   = 4,
   parameter int PRESCALE     = 100000,
   parameter int BLANK_CYCLES = 1000
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          en,
   input  logic                          lz_blank,
   input  logic [4*NUM_DIGITS-1:0]       digits,
   input  logic [NUM_DIGITS-1:0]         dp_in,
   output logic [NUM_DIGITS-1:0]         an,
   output logic [6:0]                    seg,
   output logic                          dp,
   output logic [((NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1)-1:0] digit_idx,
   output logic                          frame_tick
);

   localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam int CW = $clog2(PRESCALE);
   localparam logic [CW-1:0] CNT_LAST  = CW'(PRESCALE - 1);
   localparam logic [CW-1:0] BLANK_LIM = CW'(BLANK_CYCLES);
   localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_DIGITS - 1);

   logic [CW-1:0]           cnt_reg;
   logic [IW-1:0]           idx_reg;
   logic [4*NUM_DIGITS-1:0] shadow_digits_reg;
   logic [NUM_DIGITS-1:0]   shadow_dp_reg;
   logic                    shadow_lz_reg;

   // A frame starts in the first enabled cycle of slot 0. The display content
   // for the whole frame is captured in that cycle.
   logic load;
   assign load = en && (cnt_reg == '0) && (idx_reg == '0);

   // While the capture is happening, the output path reads the incoming values
   // directly. With zero dead time, the first cycle of a frame therefore already
   // shows the new content and not the previous frame's content.
   logic [4*NUM_DIGITS-1:0] eff_digits;
   logic [NUM_DIGITS-1:0]   eff_dp;
   logic                    eff_lz;
   assign eff_digits = load ? digits   : shadow_digits_reg;
   assign eff_dp     = load ? dp_in    : shadow_dp_reg;
   assign eff_lz     = load ? lz_blank : shadow_lz_reg;

   // Per-digit view:
   //   nib      - the digit's nibble.
   //   zero_from[i] - set when digits NUM_DIGITS-1 down to i are all zero.
   //   blank_vec - marks the leading zeros to blank. Digit 0 is never blanked.
   //   an_lit   - the active-low anode pattern for each slot.
   logic [3:0]            nib [NUM_DIGITS];
   logic [NUM_DIGITS:0]   zero_from;
   logic [NUM_DIGITS-1:0] blank_vec;
   logic [NUM_DIGITS-1:0] an_lit;

   assign zero_from[NUM_DIGITS] = 1'b1;

   generate
      for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
         assign nib[gi]       = eff_digits[4*gi +: 4];
         assign zero_from[gi] = (nib[gi] == 4'h0) && zero_from[gi+1];
         assign an_lit[gi]    = (idx_reg != IW'(gi));
         if (gi == 0) begin : g_first
            assign blank_vec[gi] = 1'b0;
         end else begin : g_rest
            assign blank_vec[gi] = eff_lz && zero_from[gi];
         end
      end
   endgenerate

   logic [3:0] cur_nib;
   logic       cur_blank;
   logic       cur_dp;
   logic       in_dead;
   assign cur_nib   = nib[idx_reg];
   assign cur_blank = blank_vec[idx_reg];
   assign cur_dp    = eff_dp[idx_reg];
   assign in_dead   = (BLANK_CYCLES > 0) && (cnt_reg < BLANK_LIM);

   // Hex nibble to active-low segments {g,f,e,d,c,b,a}.
   function automatic logic [6:0] hex7(input logic [3:0] v);
      logic [6:0] s;
      s = 7'h7F;
      case (v)
         4'h0: s = 7'h40;
         4'h1: s = 7'h79;
         4'h2: s = 7'h24;
         4'h3: s = 7'h30;
         4'h4: s = 7'h19;
         4'h5: s = 7'h12;
         4'h6: s = 7'h02;
         4'h7: s = 7'h78;
         4'h8: s = 7'h00;
         4'h9: s = 7'h10;
         4'hA: s = 7'h08;
         4'hB: s = 7'h03;
         4'hC: s = 7'h46;
         4'hD: s = 7'h21;
         4'hE: s = 7'h06;
         4'hF: s = 7'h0E;
         default: s = 7'h7F;
      endcase
      return s;
   endfunction

   // Slot timer and digit index. Both advance only while scanning is enabled,
   // and the frame content is captured at the start of each frame.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_reg           <= '0;
         idx_reg           <= '0;
         shadow_digits_reg <= '0;
         shadow_dp_reg     <= '0;
         shadow_lz_reg     <= 1'b0;
      end else if (en) begin
         if (cnt_reg == CNT_LAST) begin
            cnt_reg <= '0;
            idx_reg <= (idx_reg == IDX_LAST) ? '0 : idx_reg + 1'b1;
         end else begin
            cnt_reg <= cnt_reg + 1'b1;
         end
         if (load) begin
            shadow_digits_reg <= digits;
            shadow_dp_reg     <= dp_in;
            shadow_lz_reg     <= lz_blank;
         end
      end
   end

   // Registered pin drivers. All outputs are dark when scanning is paused or
   // during dead time. Otherwise the current slot's digit is driven.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         an         <= '1;
         seg        <= 7'h7F;
         dp         <= 1'b1;
         digit_idx  <= '0;
         frame_tick <= 1'b0;
      end else begin
         digit_idx  <= idx_reg;
         frame_tick <= en && (cnt_reg == CNT_LAST) && (idx_reg == IDX_LAST);
         if (!en || in_dead) begin
            an  <= '1;
            seg <= 7'h7F;
            dp  <= 1'b1;
         end else begin
            an  <= an_lit;
            seg <= cur_blank ? 7'h7F : hex7(cur_nib);
            dp  <= ~cur_dp;
         end
      end
   end

endmodule

// File: tb/tb_display_scan_mux.sv
// Directed testbench for display_scan_mux (4 digits, 8-cycle slots, 2 dead cycles).
module tb_display_scan_mux;

   logic        clk = 1'b0;
   logic        rst;
   logic        en;
   logic        lz_blank;
   logic [15:0] digits;
   logic [3:0]  dp_in;
   logic [3:0]  an;
   logic [6:0]  seg;
   logic        dp;
   logic [1:0]  digit_idx;
   logic        frame_tick;

   int checks = 0;
   int errors = 0;
   int n;

   display_scan_mux #(
      .NUM_DIGITS  (4),
      .PRESCALE    (8),
      .BLANK_CYCLES(2)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .en        (en),
      .lz_blank  (lz_blank),
      .digits    (digits),
      .dp_in     (dp_in),
      .an        (an),
      .seg       (seg),
      .dp        (dp),
      .digit_idx (digit_idx),
      .frame_tick(frame_tick)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Advance k clock edges and sample 1 time unit after the last edge.
   task automatic tick(input int k);
      repeat (k) @(posedge clk);
      #1;
   endtask

   // Advance until frame_tick is seen, with a bound. Returns the cycles taken.
   task automatic next_frame(output int cycles);
      logic found;
      found  = 1'b0;
      cycles = 0;
      for (int i = 0; i < 40; i++) begin
         tick(1);
         cycles++;
         if (frame_tick) begin
            found = 1'b1;
            break;
         end
      end
      chk("frame_found", {31'd0, found}, 32'd1);
   endtask

   task automatic chk_lit(input string tag, input logic [3:0] e_an, input logic [6:0] e_seg,
                          input logic e_dp);
      chk({tag, "_an"},  {28'd0, an},  {28'd0, e_an});
      chk({tag, "_seg"}, {25'd0, seg}, {25'd0, e_seg});
      chk({tag, "_dp"},  {31'd0, dp},  {31'd0, e_dp});
   endtask

   // At most one anode may be low at any time.
   always @(negedge clk) begin
      if (rst === 1'b0) begin
         checks++;
         assert ($countones(~an) <= 1) else begin
            errors++;
            $error("FAIL onehot_an observed=%b expected=at_most_one_low", an);
         end
      end
   end

   initial begin
      rst = 1'b1; en = 1'b1; lz_blank = 1'b0; digits = 16'h1234; dp_in = 4'b0000;

      // Reset state.
      tick(2);
      chk_lit("reset", 4'hF, 7'h7F, 1'b1);
      chk("reset_tick", {31'd0, frame_tick}, 32'd0);
      chk("reset_idx",  {30'd0, digit_idx},  32'd0);
      rst = 1'b0;
      $display("step: reset released, digits=1234");

      // Test 1: basic scan of 1234.
      tick(1); chk("t1_dead1_an", {28'd0, an}, 32'hF);
      tick(1); chk("t1_dead2_an", {28'd0, an}, 32'hF);
      tick(1); chk_lit("t1_d0", 4'hE, 7'h19, 1'b1);
      chk("t1_d0_idx", {30'd0, digit_idx}, 32'd0);
      tick(5); chk("t1_d0_end_an", {28'd0, an}, 32'hE);
      tick(1); chk("t1_s1_dead_an", {28'd0, an}, 32'hF);
      chk("t1_s1_idx", {30'd0, digit_idx}, 32'd1);
      tick(2); chk_lit("t1_d1", 4'hD, 7'h30, 1'b1);
      tick(8); chk_lit("t1_d2", 4'hB, 7'h24, 1'b1);
      tick(8); chk_lit("t1_d3", 4'h7, 7'h79, 1'b1);
      tick(4); chk("t1_no_tick", {31'd0, frame_tick}, 32'd0);
      tick(1); chk("t1_tick", {31'd0, frame_tick}, 32'd1);
      chk("t1_tick_an", {28'd0, an}, 32'h7);
      tick(1); chk("t1_tick_gone", {31'd0, frame_tick}, 32'd0);
      chk("t1_wrap_idx", {30'd0, digit_idx}, 32'd0);
      next_frame(n);
      chk("t1_period", n, 32'd31);

      // Test 2: leading-zero blanking.
      $display("step: digits=0050 lz_blank=1");
      digits = 16'h0050; lz_blank = 1'b1;
      tick(3);  chk_lit("t2_d0", 4'hE, 7'h40, 1'b1);
      tick(8);  chk_lit("t2_d1", 4'hD, 7'h12, 1'b1);
      tick(8);  chk_lit("t2_d2", 4'hB, 7'h7F, 1'b1);
      tick(8);  chk_lit("t2_d3", 4'h7, 7'h7F, 1'b1);
      next_frame(n);
      $display("step: digits=0000 lz_blank=1");
      digits = 16'h0000;
      tick(3);  chk_lit("t2z_d0", 4'hE, 7'h40, 1'b1);
      tick(8);  chk_lit("t2z_d1", 4'hD, 7'h7F, 1'b1);
      tick(16); chk_lit("t2z_d3", 4'h7, 7'h7F, 1'b1);
      next_frame(n);

      // Test 3: no tearing when digits change mid-frame.
      $display("step: digits=1111 then 2222 during idx 2");
      digits = 16'h1111; lz_blank = 1'b0;
      tick(19); chk_lit("t3_d2_old", 4'hB, 7'h79, 1'b1);
      digits = 16'h2222;
      tick(8);  chk_lit("t3_d3_old", 4'h7, 7'h79, 1'b1);
      next_frame(n);
      tick(3);  chk_lit("t3_d0_new", 4'hE, 7'h24, 1'b1);
      tick(16); chk_lit("t3_d2_new", 4'hB, 7'h24, 1'b1);
      next_frame(n);

      // Test 4: pause at idx 1, cnt 5.
      $display("step: pause at idx 1 cnt 5 for 10 cycles");
      tick(13); chk("t4_pre_an", {28'd0, an}, 32'hD);
      en = 1'b0;
      tick(1);  chk("t4_pause_an", {28'd0, an}, 32'hF);
      chk("t4_pause_idx", {30'd0, digit_idx}, 32'd1);
      tick(9);  chk_lit("t4_pause_end", 4'hF, 7'h7F, 1'b1);
      chk("t4_pause_end_idx", {30'd0, digit_idx}, 32'd1);
      en = 1'b1;
      tick(1);  chk_lit("t4_resume1", 4'hD, 7'h24, 1'b1);
      chk("t4_resume_idx", {30'd0, digit_idx}, 32'd1);
      tick(1);  chk("t4_resume2_an", {28'd0, an}, 32'hD);
      tick(2);  chk("t4_next_an", {28'd0, an}, 32'hF);
      chk("t4_next_idx", {30'd0, digit_idx}, 32'd2);
      tick(2);  chk("t4_next_lit_an", {28'd0, an}, 32'hB);

      // Test 5: asynchronous reset in the middle of a lit slot.
      $display("step: async reset mid-slot");
      digits = 16'h8888; dp_in = 4'b0100;
      #2; rst = 1'b1; #1;
      chk_lit("t5_async", 4'hF, 7'h7F, 1'b1);
      chk("t5_async_idx", {30'd0, digit_idx}, 32'd0);
      tick(1);
      rst = 1'b0;
      tick(1);  chk("t5_dead1_an", {28'd0, an}, 32'hF);
      tick(1);  chk("t5_dead2_an", {28'd0, an}, 32'hF);
      tick(1);  chk("t5_first_an", {28'd0, an}, 32'hE);
      chk("t5_first_idx", {30'd0, digit_idx}, 32'd0);

      // Test 6: decimal point on digit 2 only, all digits show 8.
      $display("step: digits=8888 dp_in=0100");
      chk_lit("t6_d0", 4'hE, 7'h00, 1'b1);
      tick(8);  chk_lit("t6_d1", 4'hD, 7'h00, 1'b1);
      tick(6);  chk_lit("t6_d2_dead", 4'hF, 7'h7F, 1'b1);
      tick(2);  chk_lit("t6_d2", 4'hB, 7'h00, 1'b0);
      tick(5);  chk("t6_d2_end_dp", {31'd0, dp}, 32'd0);
      tick(1);  chk("t6_d3_dead_dp", {31'd0, dp}, 32'd1);
      tick(2);  chk_lit("t6_d3", 4'h7, 7'h00, 1'b1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
